demux_1_3_stream: RTL and testbench
===================================

// Module: demux_1_3_stream
// PURPOSE
//  Registered 1-to-3 stream demultiplexer: the distributing counterpart of the
//  3:1 selector. One input word is steered by select s to one of three output
//  channels, each holding a one-entry buffer with valid/ready handshake.
//  Sits between a single producer and three independent consumers.
//  Illegal select (s = 2'b11) drops the word and counts it.
// PARAMETERS
//  WIDTH    3   data width of d and each y channel
//  CNT_W    8   width of the saturating drop counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  s          in   2      channel select, sampled with d when in_valid & in_ready
//  d          in   WIDTH  input data word
//  in_valid   in   1      producer has a word on d/s
//  in_ready   out  1      block accepts the word this cycle
//  y0,y1,y2   out  WIDTH  channel data (registered)
//  v0,v1,v2   out  1      channel word valid
//  r0,r1,r2   in   1      consumer ready per channel
//  drop_cnt   out  CNT_W  number of words dropped for s = 2'b11, saturating
//  drop       out  1      one-cycle pulse, registered, when a word is dropped
// BEHAVIOUR
//  - Reset (sync, active-high, dominates all other events): v0..v2 = 0,
//    y0..y2 = 0, drop_cnt = 0, drop = 0. in_ready = 1 during the cycle after reset
//    (all buffers empty). Reset mid-transfer discards buffered words; no output
//    handshake completes on a reset cycle.
//  - Per channel k, buffer state EMPTY (vk=0) or FULL (vk=1):
//      EMPTY -> FULL on accept with s=k; FULL -> EMPTY on vk & rk with no new
//      accept for k; FULL -> FULL (yk replaced) on vk & rk and accept for k in
//      the same cycle. FULL without rk: yk, vk held stable.
//  - in_ready (combinational) = 1 if s = 2'b11, else (~vk | rk) for k = s.
//    Depends on s and on rk (same cycle); no path from in_valid to in_ready.
//  - Accept = in_valid & in_ready. On accept with s=k in 0..2: yk <= d, vk <= 1
//    at next edge (latency 1 cycle: word visible on yk the cycle after accept).
//    The other two channels are unaffected.
//  - Accept with s = 2'b11: no channel written; drop <= 1 for one cycle;
//    drop_cnt increments, saturating at 2^CNT_W-1 (no wrap).
//  - Channels drain independently; a stalled channel never blocks words
//    steered to other channels.
//  - Full throughput: one word per cycle when the target consumer holds rk = 1.
//  - in_valid = 0: no state changes except output drains.
//  - s and d are don't-care when in_valid = 0; X on them must not corrupt state.
// TESTING
//  1 Reset: assert reset with v1 FULL -> next cycle v0..v2=0, y*=0, drop_cnt=0.
//  2 Routing: d=3'b000 s=0, d=3'b001 s=1, d=3'b010 s=2, all r=1 -> y0=000,
//    y1=001, y2=010, each valid exactly one cycle, one cycle after its accept.
//  3 Backpressure: r1=0, send d=3'b101 s=1 then d=3'b110 s=1 -> in_ready=0 on
//    second word, y1 holds 101; raise r1 -> 101 consumed, 110 accepted same cycle.
//  4 Independence: r0=0 with v0 FULL, send s=2 d=3'b011 -> accepted, y2=011, v2=1.
//  5 Illegal select: s=2'b11 for 300 accepted words -> drop pulses each, no vk
//    asserted, drop_cnt saturates at 255 (CNT_W=8).
//  6 Streaming: 16 back-to-back words cycling s=0,1,2, all r=1 -> in_ready held
//    1, every word appears on correct channel in order, no loss/duplication.

Source files
------------

// File: rtl/demux_1_3_stream.sv
// Registered 1-to-3 stream demux: each channel owns a one-entry buffer, 1-cycle accept-to-output latency.
// Backpressure: in_ready follows only the selected channel (free or draining); select 2'b11 is always accepted and dropped.
module demux_1_3_stream #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       s,
    input  logic [WIDTH-1:0] d,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic             v0,
    output logic             v1,
    output logic             v2,
    input  logic             r0,
    input  logic             r1,
    input  logic             r2,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             drop
);

    logic       accept;
    logic [2:0] wr;
    logic       is_drop;

    // A full buffer can still take a word in the cycle its consumer drains it.
    always_comb begin
        in_ready = 1'b1;
        case (s)
            2'd0:    in_ready = ~v0 | r0;
            2'd1:    in_ready = ~v1 | r1;
            2'd2:    in_ready = ~v2 | r2;
            default: in_ready = 1'b1;
        endcase
    end

    // Gating with in_valid first keeps an unknown s/d from reaching state while idle.
    assign accept  = in_valid & in_ready;
    assign wr[0]   = accept & (s == 2'd0);
    assign wr[1]   = accept & (s == 2'd1);
    assign wr[2]   = accept & (s == 2'd2);
    assign is_drop = accept & (s == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            y0       <= '0;
            y1       <= '0;
            y2       <= '0;
            v0       <= 1'b0;
            v1       <= 1'b0;
            v2       <= 1'b0;
            drop     <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wr[0]) begin
                y0 <= d;
                v0 <= 1'b1;
            end else if (r0) begin
                v0 <= 1'b0;
            end

            if (wr[1]) begin
                y1 <= d;
                v1 <= 1'b1;
            end else if (r1) begin
                v1 <= 1'b0;
            end

            if (wr[2]) begin
                y2 <= d;
                v2 <= 1'b1;
            end else if (r2) begin
                v2 <= 1'b0;
            end

            drop <= is_drop;
            if (is_drop && (drop_cnt != {CNT_W{1'b1}}))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_demux_1_3_stream.sv
// Bench for demux_1_3_stream: per-channel expected-word queues filled on accept, drained by an output monitor.
module tb_demux_1_3_stream;
    localparam int W  = 3;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    s;
    logic [W-1:0]  d;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  y0, y1, y2;
    logic          v0, v1, v2;
    logic          r0, r1, r2;
    logic [CW-1:0] drop_cnt;
    logic          drop;

    int ncmp = 0;
    int nerr = 0;
    int exp_cnt = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];
    logic [W-1:0] e0, e1, e2;

    demux_1_3_stream #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .s(s), .d(d), .in_valid(in_valid), .in_ready(in_ready),
        .y0(y0), .y1(y1), .y2(y2), .v0(v0), .v1(v1), .v2(v2),
        .r0(r0), .r1(r1), .r2(r2), .drop_cnt(drop_cnt), .drop(drop)
    );

    always #5 clk = ~clk;

    // Output monitor: a handshake visible at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (!reset) begin
            if (v0 && r0) begin
                ncmp++;
                if (q0.size() == 0) begin
                    nerr++; $display("FAIL ch0_unexpected: got y0=%b, expected no word", y0);
                end else begin
                    e0 = q0.pop_front();
                    if (y0 !== e0) begin nerr++; $display("FAIL ch0_data: got %b, expected %b", y0, e0); end
                end
            end
            if (v1 && r1) begin
                ncmp++;
                if (q1.size() == 0) begin
                    nerr++; $display("FAIL ch1_unexpected: got y1=%b, expected no word", y1);
                end else begin
                    e1 = q1.pop_front();
                    if (y1 !== e1) begin nerr++; $display("FAIL ch1_data: got %b, expected %b", y1, e1); end
                end
            end
            if (v2 && r2) begin
                ncmp++;
                if (q2.size() == 0) begin
                    nerr++; $display("FAIL ch2_unexpected: got y2=%b, expected no word", y2);
                end else begin
                    e2 = q2.pop_front();
                    if (y2 !== e2) begin nerr++; $display("FAIL ch2_data: got %b, expected %b", y2, e2); end
                end
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accepting posedge.
    task automatic send(input logic [1:0] ss, input logic [W-1:0] dd, output int waited);
        waited = 0;
        in_valid = 1'b1; s = ss; d = dd;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            ncmp++; nerr++;
            $display("FAIL send_timeout: in_ready=%b after %0d cycles, expected 1", in_ready, waited);
        end else begin
            case (ss)
                2'd0: q0.push_back(dd);
                2'd1: q1.push_back(dd);
                2'd2: q2.push_back(dd);
                default: if (exp_cnt < 255) exp_cnt++;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; s = 'x; d = 'x;
        ncmp++;
        if (drop !== (ss == 2'd3)) begin
            nerr++; $display("FAIL drop_pulse: got %b, expected %b", drop, (ss == 2'd3));
        end
        ncmp++;
        if (drop_cnt !== CW'(exp_cnt)) begin
            nerr++; $display("FAIL drop_cnt: got %0d, expected %0d", drop_cnt, exp_cnt);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        int w;
        reset = 1'b1; in_valid = 1'b0; s = 2'd0; d = '0; r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
        idle(2);
        reset = 1'b0;
        ncmp++;
        if ({v0, v1, v2, drop, drop_cnt} !== '0 || {y0, y1, y2} !== '0) begin
            nerr++; $display("FAIL reset_initial: got v=%b%b%b y=%b/%b/%b cnt=%0d drop=%b, expected all 0",
                             v0, v1, v2, y0, y1, y2, drop_cnt, drop);
        end
        ncmp++;
        if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %b, expected 1", in_ready); end
        send(2'd1, 3'b111, w);
        ncmp++;
        if (v1 !== 1'b1) begin nerr++; $display("FAIL reset_prefill: got v1=%b, expected 1", v1); end
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); exp_cnt = 0;
        ncmp++;
        if ({v0, v1, v2, drop, drop_cnt} !== '0 || {y0, y1, y2} !== '0) begin
            nerr++; $display("FAIL reset_midflight: got v=%b%b%b y=%b/%b/%b cnt=%0d, expected all 0",
                             v0, v1, v2, y0, y1, y2, drop_cnt);
        end
    endtask

    task automatic test_routing;
        int w;
        logic [W-1:0] pat [3];
        pat[0] = 3'b000; pat[1] = 3'b001; pat[2] = 3'b010;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            send(2'(k), pat[k], w);
            ncmp++;
            if ({v2, v1, v0} !== 3'(1 << k) || (k == 0 && y0 !== pat[0]) ||
                (k == 1 && y1 !== pat[1]) || (k == 2 && y2 !== pat[2])) begin
                nerr++; $display("FAIL route_ch%0d: got v=%b%b%b y=%b/%b/%b, expected word %b on ch%0d only",
                                 k, v2, v1, v0, y2, y1, y0, pat[k], k);
            end
            idle(1);
            ncmp++;
            if ({v2, v1, v0} !== 3'b000) begin
                nerr++; $display("FAIL route_onecycle%0d: got v=%b%b%b, expected 000", k, v2, v1, v0);
            end
        end
    endtask

    task automatic test_backpressure;
        int w;
        r1 = 1'b0;
        send(2'd1, 3'b101, w);
        in_valid = 1'b1; s = 2'd1; d = 3'b110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ncmp++;
            if (in_ready !== 1'b0 || y1 !== 3'b101 || v1 !== 1'b1) begin
                nerr++; $display("FAIL bp_hold%0d: got ready=%b y1=%b v1=%b, expected 0/101/1", i, in_ready, y1, v1);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        r1 = 1'b1;
        send(2'd1, 3'b110, w);
        ncmp++;
        if (w != 0 || y1 !== 3'b110 || v1 !== 1'b1) begin
            nerr++; $display("FAIL bp_release: got wait=%0d y1=%b v1=%b, expected 0/110/1", w, y1, v1);
        end
        idle(1);
        ncmp++;
        if (v1 !== 1'b0 || q1.size() != 0) begin
            nerr++; $display("FAIL bp_drain: got v1=%b pending=%0d, expected 0/0", v1, q1.size());
        end
    endtask

    task automatic test_independence;
        int w;
        r0 = 1'b0;
        send(2'd0, 3'b100, w);
        send(2'd2, 3'b011, w);
        ncmp++;
        if (w != 0 || v2 !== 1'b1 || y2 !== 3'b011 || v0 !== 1'b1 || y0 !== 3'b100) begin
            nerr++; $display("FAIL indep: got wait=%0d v2=%b y2=%b v0=%b y0=%b, expected 0/1/011/1/100",
                             w, v2, y2, v0, y0);
        end
        r0 = 1'b1;
        idle(2);
    endtask

    task automatic test_illegal;
        int w;
        int bad = 0;
        for (int i = 0; i < 300; i++) begin
            send(2'd3, 3'(i), w);
            if ({v0, v1, v2} !== 3'b000) bad++;
        end
        ncmp++;
        if (bad != 0) begin nerr++; $display("FAIL illegal_valid: got %0d cycles with a channel valid, expected 0", bad); end
        ncmp++;
        if (drop_cnt !== 8'd255) begin nerr++; $display("FAIL illegal_sat: got %0d, expected 255", drop_cnt); end
        idle(1);
        ncmp++;
        if (drop !== 1'b0 || drop_cnt !== 8'd255) begin
            nerr++; $display("FAIL illegal_idle: got drop=%b cnt=%0d, expected 0/255", drop, drop_cnt);
        end
    endtask

    task automatic test_back_to_back;
        int w;
        int stalls = 0;
        r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(2'(i % 3), 3'($urandom_range(0, 7)), w);
            stalls += w;
        end
        idle(3);
        ncmp++;
        if (stalls != 0) begin nerr++; $display("FAIL stream_stall: got %0d stall cycles, expected 0", stalls); end
        ncmp++;
        if (q0.size() + q1.size() + q2.size() != 0 || {v0, v1, v2} !== 3'b000) begin
            nerr++; $display("FAIL stream_loss: got pending=%0d/%0d/%0d v=%b%b%b, expected none",
                             q0.size(), q1.size(), q2.size(), v0, v1, v2);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_backpressure();
        test_independence();
        test_illegal();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
